// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the four-master round-robin bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned BUS_MASTER_NUM = 4;
    localparam int unsigned BUS_OWNER_W    = 2;

    // Owner index, the [1:0] owner bus.
    typedef logic [BUS_OWNER_W-1:0]    bus_owner_t;
    // One bit per master, bit n belongs to master n.
    typedef logic [BUS_MASTER_NUM-1:0] bus_vec_t;

    localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

    // Active-low strobe levels shared by requests and grants.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Active-low grant vector that enables only the indexed master.
    function automatic bus_vec_t grant_decode(input bus_owner_t idx);
        bus_vec_t g;
        g = {BUS_MASTER_NUM{DISABLE_}};
        g[idx] = ENABLE_;
        return g;
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Round-robin next-owner search: first requester after the owner, wrapping.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  bus_owner_t owner,
    input  bus_vec_t   req,
    output bus_owner_t next,
    output logic       contention
);

    bus_owner_t cand;

    // Walk the search order from farthest to nearest so the nearest requester wins.
    always_comb begin
        cand       = owner;
        next       = owner + BUS_OWNER_W'(1);
        contention = 1'b0;
        for (int k = BUS_MASTER_NUM - 1; k >= 1; k--) begin
            cand = owner + BUS_OWNER_W'(k);
            if (req[cand]) begin
                next       = cand;
                contention = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master bus arbiter with round-robin handoff and hold-time preemption.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0Req_,
    input  logic       m1Req_,
    input  logic       m2Req_,
    input  logic       m3Req_,
    output logic       m0Grnt_,
    output logic       m1Grnt_,
    output logic       m2Grnt_,
    output logic       m3Grnt_,
    output bus_owner_t owner,
    output logic       preempt
);

    // Counter only needs to reach HOLD_MAX-1; keep at least one bit.
    localparam int unsigned       CNT_W      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST  = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_SAT    = '1;
    localparam logic              PREEMPT_EN = (HOLD_MAX != 0);

    bus_vec_t          req;
    bus_vec_t          grnt_c;
    bus_owner_t        next_owner;
    logic              contention;
    logic              owner_req;
    logic              rel_c;
    logic              timeout_c;

    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  hold_cnt_nxt;
    bus_owner_t        owner_nxt;
    logic              preempt_nxt;

    // Internal request vector is active-high.
    assign req = ~{m3Req_, m2Req_, m1Req_, m0Req_};

    bus_arb_rr_pick u_pick (
        .owner      (owner),
        .req        (req),
        .next       (next_owner),
        .contention (contention)
    );

    assign owner_req = req[owner];
    assign rel_c     = ~owner_req;
    assign timeout_c = PREEMPT_EN && (hold_cnt == HOLD_LAST) && owner_req && contention;

    // Next owner, hold count and preempt flag; release takes priority over timeout.
    always_comb begin
        owner_nxt    = owner;
        hold_cnt_nxt = hold_cnt;
        preempt_nxt  = 1'b0;
        if ((rel_c || timeout_c) && contention) begin
            owner_nxt    = next_owner;
            hold_cnt_nxt = '0;
            preempt_nxt  = ~rel_c;
        end else if (rel_c) begin
            hold_cnt_nxt = '0;
        end else if (contention) begin
            // Saturate so the count never wraps when preemption is disabled.
            if (hold_cnt != CNT_SAT) begin
                hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
        end else begin
            hold_cnt_nxt = '0;
        end
    end

    // Arbiter state registers with asynchronous reset to master 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= BUS_OWNER_MASTER_0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            owner    <= owner_nxt;
            hold_cnt <= hold_cnt_nxt;
            preempt  <= preempt_nxt;
        end
    end

    // Grants are a pure decode of the owner register, so exactly one is enabled.
    assign grnt_c  = grant_decode(owner);
    assign m0Grnt_ = grnt_c[0];
    assign m1Grnt_ = grnt_c[1];
    assign m2Grnt_ = grnt_c[2];
    assign m3Grnt_ = grnt_c[3];

endmodule
